// File: rtl/logic_accum_unit_pkg.sv
// Shared encodings for the logic-reduction family: operation codes and FSM states.
// Latency: none (definitions only).
// Backpressure: n/a.
//
// Contents: op_t, OP_* codes, ST_* state codes, default parameters, f_base_op().
package logic_accum_unit_pkg;

   typedef logic [1:0] op_t;

   // Operation encodings as seen on the op input.
   localparam op_t OP_OR  = 2'b00;
   localparam op_t OP_AND = 2'b01;
   localparam op_t OP_XOR = 2'b10;
   localparam op_t OP_NOR = 2'b11;

   // FSM state encodings, kept as plain constants so older blocks can share them.
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_ACCUM = 2'b01;
   localparam logic [1:0] ST_HOLD  = 2'b10;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_NUM_IN    = 2;
   localparam int DEF_MAX_BEATS = 16;

   // NOR reduces and accumulates as OR; the inversion is applied once at the output.
   function automatic op_t f_base_op(input op_t op);
      return (op == OP_NOR) ? OP_OR : op;
   endfunction

endpackage

// File: rtl/logic_accum_unit_if.sv
// Handshake bundle for logic_accum_unit: operand beats in, reduced result out.
// Latency: none (wiring only).
// Backpressure: in_ready / out_ready carry flow control in each direction.
//
// master: drives in_valid, a, op, mode, beats, out_ready; observes in_ready, out_valid, c.
// slave : the accumulation unit side of the same signals.
interface logic_accum_unit_if
   import logic_accum_unit_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_IN    = DEF_NUM_IN,
   parameter int MAX_BEATS = DEF_MAX_BEATS
);
   localparam int CW = $clog2(MAX_BEATS + 1);

   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_IN*WIDTH-1:0] a;
   op_t                     op;
   logic                    mode;
   logic [CW-1:0]           beats;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        c;

   modport master (
      output in_valid, a, op, mode, beats, out_ready,
      input  in_ready, out_valid, c
   );

   modport slave (
      input  in_valid, a, op, mode, beats, out_ready,
      output in_ready, out_valid, c
   );

endinterface

// File: rtl/logic_accum_unit_reduce.sv
// Combinational bitwise reduction of NUM_IN channels into one WIDTH-bit value.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller qualifies the result with its own handshake.
//
// Ports: i_op (base op; NOR is treated as OR here), i_a (packed channels), o_r (reduced value).
module logic_reduce
   import logic_accum_unit_pkg::*;
#(
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int WIDTH  = DEF_WIDTH
)
(
   input  op_t                     i_op,
   input  logic [NUM_IN*WIDTH-1:0] i_a,
   output logic [WIDTH-1:0]        o_r
);

   always_comb begin
      o_r = i_a[WIDTH-1:0];
      for (int i = 1; i < NUM_IN; i++) begin
         case (i_op)
            OP_AND:  o_r = o_r & i_a[i*WIDTH +: WIDTH];
            OP_XOR:  o_r = o_r ^ i_a[i*WIDTH +: WIDTH];
            default: o_r = o_r | i_a[i*WIDTH +: WIDTH];
         endcase
      end
   end

endmodule

// File: rtl/logic_accum_unit.sv
// Reduces NUM_IN operand channels per beat and accumulates over L beats into register C.
// Latency: result valid on the edge accepting the L-th beat (1 cycle in single mode).
// Backpressure: while holding a result, in_ready follows out_ready combinationally.
//
// Ports: i_clk, i_rst (async, active-high), if_bus (slave side of logic_accum_unit_if).
module logic_accum_unit
   import logic_accum_unit_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_IN    = DEF_NUM_IN,
   parameter int MAX_BEATS = DEF_MAX_BEATS
)
(
   input logic               i_clk,
   input logic               i_rst,
   logic_accum_unit_if.slave if_bus
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] LEN_MAX = CW'(MAX_BEATS);
   localparam logic [CW-1:0] LEN_ONE = CW'(1);

   logic [1:0]       r_state;
   op_t              r_op;
   logic [CW-1:0]    r_len;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_c;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_first;
   op_t              w_op_eff;
   op_t              w_base_op;
   logic [CW-1:0]    w_len_new;
   logic [CW-1:0]    w_len_eff;
   logic [CW-1:0]    w_cnt_next;
   logic             w_last;
   logic [WIDTH-1:0] w_r;
   logic [WIDTH-1:0] w_comb;
   logic [WIDTH-1:0] w_result;

   // In HOLD the slot frees up exactly when downstream takes C, so a new frame's
   // first beat can be accepted in the same cycle as the pop.
   assign w_in_ready = !i_rst && ((r_state != ST_HOLD) || if_bus.out_ready);
   assign w_accept   = if_bus.in_valid && w_in_ready;

   // Any beat accepted outside ACCUM starts a new frame (IDLE or HOLD-with-pop).
   assign w_first    = (r_state != ST_ACCUM);

   // Frame settings come live from the bus on the first beat, from latches afterwards.
   assign w_op_eff   = w_first ? if_bus.op : r_op;
   assign w_base_op  = f_base_op(w_op_eff);

   always_comb begin
      w_len_new = LEN_ONE;
      if (if_bus.mode) begin
         if (if_bus.beats == '0) begin
            w_len_new = LEN_ONE;
         end else if (if_bus.beats > LEN_MAX) begin
            w_len_new = LEN_MAX;
         end else begin
            w_len_new = if_bus.beats;
         end
      end
   end

   assign w_len_eff  = w_first ? w_len_new : r_len;
   assign w_cnt_next = w_first ? LEN_ONE : (r_cnt + LEN_ONE);
   assign w_last     = (w_cnt_next == w_len_eff);

   logic_reduce #(
      .NUM_IN (NUM_IN),
      .WIDTH  (WIDTH)
   ) u_reduce (
      .i_op (w_base_op),
      .i_a  (if_bus.a),
      .o_r  (w_r)
   );

   // Fold the current beat into the running value; the first beat seeds it.
   always_comb begin
      w_comb = w_r;
      if (!w_first) begin
         case (w_base_op)
            OP_AND:  w_comb = r_acc & w_r;
            OP_XOR:  w_comb = r_acc ^ w_r;
            default: w_comb = r_acc | w_r;
         endcase
      end
   end

   assign w_result = (w_op_eff == OP_NOR) ? ~w_comb : w_comb;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_OR;
         r_len   <= LEN_ONE;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_c     <= '0;
      end else if (w_accept) begin
         if (w_first) begin
            r_op  <= if_bus.op;
            r_len <= w_len_new;
         end
         if (w_last) begin
            r_c     <= w_result;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_HOLD;
         end else begin
            r_acc   <= w_comb;
            r_cnt   <= w_cnt_next;
            r_state <= ST_ACCUM;
         end
      end else if ((r_state == ST_HOLD) && if_bus.out_ready) begin
         r_state <= ST_IDLE;
      end
   end

   assign if_bus.in_ready  = w_in_ready;
   assign if_bus.out_valid = (r_state == ST_HOLD);
   assign if_bus.c         = r_c;

endmodule

// File: doc/logic_accum_unit.md
# logic_accum_unit

Parametrised, registered successor to the team's single-bit two-input OR gate. Reduces NUM_IN channels of WIDTH-bit operands bitwise with a selectable operation (OR, AND, XOR, NOR). It can accumulate that result over a programmable number of input beats before presenting it. It sits between the switch/button sampling logic and the display/LED drivers, and uses valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, bits per channel and per result.
- NUM_IN, 2, number of input channels (≥2).
- MAX_BEATS, 16, largest accumulation length (≥1).
- CW, $clog2(MAX_BEATS+1), width of BEATS and internal counter (derived localparam).
- Clock and reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  operand beat present.
- IN_READY  out  1  unit accepts beat this cycle.
- A  in  NUM_IN*WIDTH  operands; channel i at A[i*WIDTH +: WIDTH].
- OP  in  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled on first beat of a frame.
- MODE  in  1  0 single-beat, 1 accumulate; sampled on first beat.
- BEATS  in  CW  beats per frame in accumulate mode; sampled on first beat.
- OUT_VALID  out  1  result C valid.
- OUT_READY  in  1  downstream takes C.
- C  out  WIDTH  registered result.

## Operation
- Per-beat value r: bitwise reduction of all NUM_IN channels. OR/NOR use OR, AND uses AND, XOR uses XOR.
- Frame accumulator: acc = acc op r with the same base op. NOR accumulates as OR and inverts once when loading C.
- Effective length L:
  - MODE=0 gives L=1.
  - BEATS=0 is treated as 1.
  - BEATS>MAX_BEATS is clamped to MAX_BEATS.
- OP, MODE and L are latched on the first accepted beat. Changes mid-frame are ignored.
- States: IDLE, ACCUM, HOLD.
  - IDLE: IN_READY=1. On accept:
    - If L=1, load C and go to HOLD.
    - Otherwise set acc=r, cnt=1, and go to ACCUM.
  - ACCUM: IN_READY=1. On accept, acc updates and cnt increments. When the accepted beat is the L-th, load C from the combined value and go to HOLD.
  - HOLD: OUT_VALID=1, IN_READY=OUT_READY (combinational path, documented).
    - On OUT_READY without IN_VALID, go to IDLE.
    - On OUT_READY with IN_VALID, pop and accept the new frame's first beat in the same cycle. That beat is processed exactly as an IDLE acceptance (back-to-back frames, no bubble).
- C holds its last value when not in HOLD. C never changes while OUT_VALID=1 and OUT_READY=0.
- Reset, including mid-frame:
  - State goes to IDLE; C=0, acc=0, cnt=0, OUT_VALID=0.
  - IN_READY=0 while RST is high.
  - A partial frame is discarded and no output is produced for it.

## Timing
- Single mode: beat accepted at edge k; OUT_VALID=1 and C valid from edge k (visible cycle k+1). Latency 1.
- Accumulate: OUT_VALID rises on the edge that accepts the L-th beat.
- Idle beats (IN_VALID=0) in ACCUM do not advance cnt.
- Throughput:
  - Single mode sustains one result per cycle when OUT_READY is held high.
  - Accumulate mode sustains one result per L cycles.
- cnt never exceeds MAX_BEATS. It wraps to 0 on frame completion.

## Structure
- Shared include logic_ops.vh: OP encodings (OP_OR, OP_AND, OP_XOR, OP_NOR) and state encodings, reused by later logic blocks.
- Natural sub-module: logic_reduce. It is purely combinational (NUM_IN, WIDTH, OP in, r out) and is instantiated once for the per-beat reduction.
- The FSM, counter, accumulator and output register live in logic_accum_unit.

## Test plan
- Reset: assert RST mid-cycle (asynchronous) → C=0x00, OUT_VALID=0, IN_READY=0 immediately; IN_READY=1 after release.
- Single OR: WIDTH=8, NUM_IN=2, ch0=0x0F, ch1=0xF0, MODE=0 → C=0xFF, OUT_VALID one cycle after accept.
- Accumulate XOR, BEATS=3: per-beat r of 0x01, 0x03, 0x06, with an IN_VALID gap between beats 2 and 3 → C=0x04 after the third accept only.
- Accumulate NOR, BEATS=2: r values 0x10, 0x01; OP changed to AND on beat 2 → C=0xEE (OP change ignored).
- Backpressure: OUT_READY low for 5 cycles with IN_VALID high → C stable, IN_READY=0, no beat consumed. Raising OUT_READY pops and accepts the next frame's beat in the same cycle → next single-mode result appears one cycle later.
- Boundaries:
  - RST pulse after 2 of 4 beats → no OUT_VALID; the next 4-beat frame starts fresh.
  - BEATS=0 → behaves as L=1.
  - BEATS=MAX_BEATS+5 → result after exactly MAX_BEATS accepts.
